// File: rtl/sram_fifo_ctrl.sv
// Streaming byte FIFO around a 1W/1R SRAM macro with one-cycle read latency.
// A 2-entry output buffer hides the read latency so both streams run at one byte per cycle.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int PW        = ADDR_WIDTH + 1;
  localparam int LW        = ADDR_WIDTH + 2;

  logic [PW-1:0]                   wptr, rptr, avail;
  logic                            inflight;
  logic [1:0]                      obuf_cnt, tail;
  logic [1:0][DATA_WIDTH-1:0]      obuf, obuf_nxt;
  logic [ADDR_WIDTH-1:0]           addr0_q;
  logic [DATA_WIDTH-1:0]           din0_q;
  logic                            wr, rd, pop;
  logic [2:0]                      occ;

  // A write is captured at the edge ending its cycle and committed by the macro at the
  // following negedge, so it is readable from the next cycle on: avail is the pointer gap.
  assign avail   = wptr - rptr;
  assign s_ready = rst_n && (avail != PW'(RAM_DEPTH));
  assign wr      = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  // Issue only if the buffer will still have a free slot when the read data lands.
  assign occ = 3'(obuf_cnt) + 3'(inflight) - 3'(pop);
  assign rd  = rst_n && (avail != '0) && (occ < 3'd2);

  assign sram_csb0  = !wr;
  assign sram_addr0 = wr ? wptr[ADDR_WIDTH-1:0] : addr0_q;
  assign sram_din0  = wr ? s_data : din0_q;
  assign sram_csb1  = !rd;
  assign sram_addr1 = rptr[ADDR_WIDTH-1:0];

  assign m_valid = (obuf_cnt != 2'd0);
  assign m_data  = obuf[0];
  assign level   = LW'(avail) + LW'(inflight) + LW'(obuf_cnt);

  // Tail slot after this cycle's pop; only 0 or 1 can occur when a capture is pending.
  assign tail = obuf_cnt - {1'b0, pop};

  always_comb begin
    obuf_nxt = obuf;
    if (pop)      obuf_nxt[0] = obuf[1];
    if (inflight) obuf_nxt[tail[0]] = sram_dout1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
      obuf_cnt <= 2'd0;
      obuf     <= '0;
      addr0_q  <= '0;
      din0_q   <= '0;
    end else begin
      if (wr) begin
        wptr    <= wptr + PW'(1);
        addr0_q <= wptr[ADDR_WIDTH-1:0];
        din0_q  <= s_data;
      end
      if (rd) rptr <= rptr + PW'(1);
      inflight <= rd;
      obuf_cnt <= obuf_cnt + 2'(inflight) - 2'(pop);
      obuf     <= obuf_nxt;
    end
  end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: behavioural macro model, queue scoreboard checked every
// cycle, plus directed scenarios with literal expectations.
module tb_sram_fifo_ctrl;
  logic       clk, rst_n;
  logic       s_valid, s_ready, m_valid, m_ready;
  logic [7:0] s_data, m_data;
  logic [5:0] level;
  logic       sram_csb0, sram_csb1;
  logic [3:0] sram_addr0, sram_addr1;
  logic [7:0] sram_din0, sram_dout1;

  sram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level),
    .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Macro model: ports latched at posedge (sampled here at the preceding negedge),
  // write committed at the next negedge, read data valid shortly after that negedge.
  logic [7:0] mem [16];
  logic       p_w = 0, p_r = 0;
  logic [3:0] p_wa = 0, p_ra = 0;
  logic [7:0] p_wd = 0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    sram_dout1 = 8'h00;
  end

  always @(negedge clk) begin
    logic       lw, lr;
    logic [3:0] lwa, lra;
    logic [7:0] lwd;
    lw = p_w; lwa = p_wa; lwd = p_wd; lr = p_r; lra = p_ra;
    p_w = !sram_csb0; p_wa = sram_addr0; p_wd = sram_din0;
    p_r = !sram_csb1; p_ra = sram_addr1;
    if (lw && lr) chk("macro_collision", int'(lwa == lra), 0);
    if (lw) mem[lwa] = lwd;
    if (lr) begin
      #1;
      sram_dout1 = mem[lra];
    end
  end

  // Scoreboard: every byte accepted must come out in order; level is bytes held.
  logic [7:0] sb[$];
  int wcnt = 0, rcnt = 0, wraps = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_level", level, 0);
      chk("rst_csb0", sram_csb0, 1);
      chk("rst_csb1", sram_csb1, 1);
      chk("rst_s_ready", s_ready, 0);
      sb.delete();
      wcnt = 0;
      rcnt = 0;
    end else begin
      chk("level", level, sb.size());
      if (sb.size() < 16)  chk("s_ready_open", s_ready, 1);
      if (sb.size() == 18) chk("s_ready_full", s_ready, 0);
      chk("csb0", sram_csb0, int'(!(s_valid && s_ready)));
      if (m_valid) begin
        if (sb.size() == 0) chk("m_valid_empty", m_valid, 0);
        else                chk("m_data", m_data, sb[0]);
      end
      if (!sram_csb1) begin
        chk("rd_ahead", int'(rcnt < wcnt), 1);
        chk("addr1", sram_addr1, rcnt % 16);
        rcnt++;
      end
      if (!sram_csb0) begin
        chk("addr0", sram_addr0, wcnt % 16);
        chk("din0", sram_din0, s_data);
        if (wcnt > 0 && wcnt % 16 == 0) wraps++;
        wcnt++;
      end
      if (s_valid && s_ready) sb.push_back(s_data);
      if (m_valid && m_ready && sb.size() > 0) void'(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1);
  end

  task automatic drive(input logic sv, input logic [7:0] sd, input logic mr);
    @(posedge clk); #1;
    s_valid = sv; s_data = sd; m_ready = mr;
    @(negedge clk);
  endtask

  initial begin
    int k, got, reopen;
    rst_n = 0; s_valid = 0; s_data = 0; m_ready = 0;
    repeat (3) @(negedge clk);
    chk("init_s_ready", s_ready, 0);
    chk("init_level", level, 0);
    chk("init_m_valid", m_valid, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("rel_s_ready", s_ready, 1);

    // First-word latency
    drive(1, 8'h3C, 0);
    chk("lat_csb0", sram_csb0, 0);
    chk("lat_addr0", sram_addr0, 0);
    drive(0, 8'h00, 0);
    chk("lat_csb1", sram_csb1, 0);
    chk("lat_addr1", sram_addr1, 0);
    chk("lat_mv0", m_valid, 0);
    drive(0, 8'h00, 0);
    chk("lat_csb1_off", sram_csb1, 1);
    chk("lat_mv1", m_valid, 0);
    chk("lat_level", level, 1);
    drive(0, 8'h00, 0);
    chk("lat_mv2", m_valid, 1);
    chk("lat_data", m_data, 8'h3C);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);
    chk("lat_drained", m_valid, 0);
    chk("lat_level0", level, 0);

    // Streaming 64 bytes, no bubbles
    for (int c = 0; c < 70; c++) begin
      drive(c < 64, 8'(c), 1);
      if (c < 64) chk("st_s_ready", s_ready, 1);
      chk("st_m_valid", m_valid, int'(c >= 3 && c < 67));
      if (c >= 3 && c < 67) chk("st_data", m_data, (c - 3) & 8'hFF);
    end
    drive(0, 8'h00, 0);

    // Full / backpressure
    k = 0;
    for (int c = 0; c < 22; c++) begin
      drive(k < 20, 8'(8'h80 + k), 0);
      if (s_valid && s_ready) k++;
    end
    chk("full_accepted", k, 18);
    chk("full_s_ready", s_ready, 0);
    chk("full_level", level, 18);
    chk("full_head", m_data, 8'h80);
    got = 0; reopen = -1;
    for (int t = 0; t < 60 && got < 20; t++) begin
      drive(k < 20, 8'(8'h80 + k), 1);
      if (s_valid && s_ready) begin
        if (reopen < 0) reopen = t;
        k++;
      end
      if (m_valid) begin
        chk("drain_data", m_data, (8'h80 + got) & 8'hFF);
        got++;
      end
    end
    chk("reopen", int'(reopen >= 0 && reopen <= 2), 1);
    chk("drain_count", got, 20);
    chk("drain_accepted", k, 20);
    drive(0, 8'h00, 0);
    chk("drain_level", level, 0);

    // Pop concurrent with capture
    drive(1, 8'h11, 0);
    drive(1, 8'h22, 0);
    drive(1, 8'h33, 0);
    drive(1, 8'h44, 0);
    repeat (3) drive(0, 8'h00, 0);
    chk("pc_head0", m_data, 8'h11);
    chk("pc_level0", level, 4);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 1);
    chk("pc_head1", m_data, 8'h22);
    chk("pc_level1", level, 3);
    drive(0, 8'h00, 0);
    chk("pc_head2", m_data, 8'h33);
    chk("pc_level2", level, 2);
    drive(0, 8'h00, 0);
    chk("pc_head3", m_data, 8'h33);
    chk("pc_level3", level, 2);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 1);
    chk("pc_head4", m_data, 8'h44);
    drive(0, 8'h00, 0);
    chk("pc_level4", level, 0);

    // Reset mid-stream
    for (int c = 0; c < 5; c++) drive(1, 8'(8'h50 + c), 0);
    @(posedge clk); #1;
    rst_n = 0; s_valid = 1; s_data = 8'h77;
    @(negedge clk);
    chk("mr_m_valid", m_valid, 0);
    chk("mr_level", level, 0);
    chk("mr_csb0", sram_csb0, 1);
    chk("mr_csb1", sram_csb1, 1);
    @(posedge clk); #1;
    rst_n = 1; s_valid = 1; s_data = 8'hA5;
    @(negedge clk);
    chk("mr_wr_addr0", sram_addr0, 0);
    chk("mr_wr_csb0", sram_csb0, 0);
    drive(0, 8'h00, 0);
    drive(0, 8'h00, 0);
    chk("mr_mv_early", m_valid, 0);
    drive(0, 8'h00, 0);
    chk("mr_mv", m_valid, 1);
    chk("mr_data", m_data, 8'hA5);
    drive(0, 8'h00, 1);

    // Random traffic, then drain
    for (int c = 0; c < 40; c++)
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    for (int t = 0; t < 40 && level != 0; t++) drive(0, 8'h00, 1);
    chk("rand_level", level, 0);
    chk("rand_empty", m_valid, 0);
    chk("wrap_seen", int'(wraps >= 4), 1);

    drive(0, 8'h00, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
